// File: rtl/bf_mem_arbiter.sv
// Shares one req/ack memory backend between the bfcpu instruction-fetch port
// and data port; data addresses are relocated by d_base into the common space.
module bf_mem_arbiter #(
  parameter int                        i_addr_width   = 16,
  parameter int                        d_addr_width   = 8,
  parameter int                        mem_addr_width = 16,
  parameter logic [mem_addr_width-1:0] d_base         = 16'h8000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_req,
  input  logic [i_addr_width-1:0]   i_addr,
  output logic                      i_ack,
  output logic [7:0]                i_rdata,
  input  logic                      d_req,
  input  logic                      d_dir,
  input  logic [d_addr_width-1:0]   d_addr,
  input  logic [7:0]                d_wdata,
  output logic                      d_ack,
  output logic [7:0]                d_rdata,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [mem_addr_width-1:0] mem_addr,
  output logic [7:0]                mem_wdata,
  input  logic                      mem_ack,
  input  logic [7:0]                mem_rdata
);

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D} state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t                    state_reg, state_next;
  logic                      last_grant_reg, last_grant_next;
  logic                      i_ack_reg, i_ack_next;
  logic [7:0]                i_rdata_reg, i_rdata_next;
  logic                      d_ack_reg, d_ack_next;
  logic [7:0]                d_rdata_reg, d_rdata_next;
  logic                      mem_req_reg, mem_req_next;
  logic                      mem_we_reg, mem_we_next;
  logic [mem_addr_width-1:0] mem_addr_reg, mem_addr_next;
  logic [7:0]                mem_wdata_reg, mem_wdata_next;
  logic                      grant_d;

  // On a tie the port that did not win the previous tie is served.
  assign grant_d = d_req && (!i_req || (last_grant_reg == GRANT_I));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= GRANT_D;
      i_ack_reg      <= 1'b0;
      i_rdata_reg    <= 8'h00;
      d_ack_reg      <= 1'b0;
      d_rdata_reg    <= 8'h00;
      mem_req_reg    <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= 8'h00;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      i_ack_reg      <= i_ack_next;
      i_rdata_reg    <= i_rdata_next;
      d_ack_reg      <= d_ack_next;
      d_rdata_reg    <= d_rdata_next;
      mem_req_reg    <= mem_req_next;
      mem_we_reg     <= mem_we_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    case (state_reg)
      IDLE: begin
        if (i_req || d_req) begin
          state_next = grant_d ? BUSY_D : BUSY_I;
        end
        if (i_req && d_req) begin
          last_grant_next = grant_d;
        end
      end
      BUSY_I:  if (mem_ack) state_next = DONE_I;
      BUSY_D:  if (mem_ack) state_next = DONE_D;
      DONE_I:  if (!i_req)  state_next = IDLE;
      DONE_D:  if (!d_req)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs; everything holds unless changed.
  always_comb begin
    i_ack_next     = i_ack_reg;
    i_rdata_next   = i_rdata_reg;
    d_ack_next     = d_ack_reg;
    d_rdata_next   = d_rdata_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    case (state_reg)
      IDLE: begin
        if (i_req || d_req) begin
          mem_req_next = 1'b1;
          if (grant_d) begin
            mem_we_next    = d_dir;
            mem_addr_next  = d_base + mem_addr_width'(d_addr);
            mem_wdata_next = d_wdata;
          end else begin
            mem_we_next   = 1'b0;
            mem_addr_next = mem_addr_width'(i_addr);
          end
        end
      end
      BUSY_I: begin
        if (mem_ack) begin
          mem_req_next = 1'b0;
          i_ack_next   = 1'b1;
          i_rdata_next = mem_rdata;
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          mem_req_next = 1'b0;
          d_ack_next   = 1'b1;
          if (!mem_we_reg) begin
            d_rdata_next = mem_rdata;
          end
        end
      end
      DONE_I:  if (!i_req) i_ack_next = 1'b0;
      DONE_D:  if (!d_req) d_ack_next = 1'b0;
      default: ;
    endcase
  end

  assign i_ack     = i_ack_reg;
  assign i_rdata   = i_rdata_reg;
  assign d_ack     = d_ack_reg;
  assign d_rdata   = d_rdata_reg;
  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_bf_mem_arbiter.sv
// Bench for bf_mem_arbiter: two instances (d_base 8000 and FFF0) share stimulus;
// a transaction-level model predicts grants, addresses, acks and read data.
module tb_bf_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_dir, mem_ack;
  logic [15:0] i_addr;
  logic [7:0]  d_addr, d_wdata, mem_rdata;

  logic        i_ack0, d_ack0, mem_req0, mem_we0;
  logic [7:0]  i_rdata0, d_rdata0, mem_wdata0;
  logic [15:0] mem_addr0;
  logic        i_ack1, d_ack1, mem_req1, mem_we1;
  logic [7:0]  i_rdata1, d_rdata1, mem_wdata1;
  logic [15:0] mem_addr1;

  int total = 0;
  int bad   = 0;
  int ties  = 0;
  logic [7:0] m_irdata, m_drdata, m_wdata;

  bf_mem_arbiter dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack0), .i_rdata(i_rdata0),
    .d_req(d_req), .d_dir(d_dir), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack0), .d_rdata(d_rdata0),
    .mem_req(mem_req0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  bf_mem_arbiter #(.d_base(16'hFFF0)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack1), .i_rdata(i_rdata1),
    .d_req(d_req), .d_dir(d_dir), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack1), .d_rdata(d_rdata1),
    .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".dut0"}, {i_ack0, i_rdata0, d_ack0, d_rdata0, mem_req0},
        {1'b0, m_irdata, 1'b0, m_drdata, 1'b0});
    chk({tag, ".dut1"}, {i_ack1, i_rdata1, d_ack1, d_rdata1, mem_req1},
        {1'b0, m_irdata, 1'b0, m_drdata, 1'b0});
  endtask

  // Entered one cycle after the grant edge; completes the access and releases the port.
  task automatic finish_txn(input bit port, input bit we, input logic [15:0] a0,
                            input logic [15:0] a1, input logic [7:0] wd, input int lat,
                            input logic [7:0] rd, input int hold);
    if (port) m_wdata = wd;
    chk("grant.dut0", {mem_req0, mem_we0, mem_addr0, mem_wdata0, i_ack0, d_ack0},
        {1'b1, we, a0, m_wdata, 2'b00});
    chk("grant.dut1", {mem_req1, mem_we1, mem_addr1, mem_wdata1},
        {1'b1, we, a1, m_wdata});
    for (int k = 0; k < lat; k++) begin
      if (port) begin
        d_addr  = d_addr + 8'h01;
        d_wdata = ~d_wdata;
        d_dir   = ~d_dir;
      end else begin
        i_addr = i_addr + 16'h0001;
      end
      tick;
      chk("busy.hold", {mem_req0, mem_we0, mem_addr0, mem_wdata0, i_ack0, d_ack0, mem_addr1},
          {1'b1, we, a0, m_wdata, 2'b00, a1});
    end
    mem_ack   = 1'b1;
    mem_rdata = rd;
    tick;
    mem_ack   = 1'b0;
    mem_rdata = 8'($urandom);
    if (!port) m_irdata = rd;
    else if (!we) m_drdata = rd;
    for (int k = 0; k <= hold; k++) begin
      chk("done.dut0", {mem_req0, i_ack0, d_ack0, i_rdata0, d_rdata0},
          {1'b0, !port, port, m_irdata, m_drdata});
      chk("done.dut1", {mem_req1, i_ack1, d_ack1, i_rdata1, d_rdata1},
          {1'b0, !port, port, m_irdata, m_drdata});
      if (k < hold) begin
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
      end
    end
    if (port) d_req = 1'b0;
    else i_req = 1'b0;
    tick;
    chk("release", {i_ack0, d_ack0, mem_req0, i_ack1, d_ack1, mem_req1}, 6'b0);
  endtask

  task automatic serve(input bit port, input logic [15:0] ia, input logic [7:0] da,
                       input bit dir, input logic [7:0] wd, input int lat,
                       input logic [7:0] rd, input int hold);
    logic [15:0] a0, a1;
    a0 = 16'h8000 + {8'h00, da};
    a1 = 16'hFFF0 + {8'h00, da};
    if (port) finish_txn(1'b1, dir, a0, a1, wd, lat, rd, hold);
    else finish_txn(1'b0, 1'b0, ia, ia, wd, lat, rd, hold);
  endtask

  task automatic single(input bit port, input logic [15:0] ia, input logic [7:0] da,
                        input bit dir, input logic [7:0] wd, input int lat,
                        input logic [7:0] rd, input int hold);
    if (port) begin
      d_req = 1'b1; d_addr = da; d_dir = dir; d_wdata = wd;
    end else begin
      i_req = 1'b1; i_addr = ia;
    end
    tick;
    serve(port, ia, da, dir, wd, lat, rd, hold);
  endtask

  // Ties alternate, instruction port first after reset; the loser follows.
  task automatic tie(input logic [15:0] ia, input logic [7:0] da, input bit dir,
                     input logic [7:0] wd);
    bit win;
    win = (ties % 2) == 1;
    ties++;
    i_req = 1'b1; i_addr = ia;
    d_req = 1'b1; d_addr = da; d_dir = dir; d_wdata = wd;
    tick;
    serve(win, ia, da, dir, wd, $urandom_range(0, 3), 8'($urandom), $urandom_range(0, 2));
    tick;
    serve(!win, ia, da, dir, wd, $urandom_range(0, 3), 8'($urandom), $urandom_range(0, 2));
  endtask

  initial begin
    rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_dir = 1'b0; mem_ack = 1'b0;
    i_addr = 16'h0; d_addr = 8'h0; d_wdata = 8'h0; mem_rdata = 8'h0;
    m_irdata = 8'h0; m_drdata = 8'h0; m_wdata = 8'h0;
    repeat (3) tick;
    chk("reset.dut0", {i_ack0, i_rdata0, d_ack0, d_rdata0, mem_req0, mem_we0, mem_addr0, mem_wdata0}, 44'h0);
    chk("reset.dut1", {i_ack1, i_rdata1, d_ack1, d_rdata1, mem_req1, mem_we1, mem_addr1, mem_wdata1}, 44'h0);
    rst_n = 1'b1;
    tick;
    chk_quiet("idle");

    single(1'b0, 16'h0012, 8'h00, 1'b0, 8'h00, 2, 8'h2B, 2);
    single(1'b1, 16'h0000, 8'hFF, 1'b0, 8'h11, 1, 8'h3C, 1);
    single(1'b1, 16'h0000, 8'h05, 1'b1, 8'hA7, 1, 8'h99, 0);
    single(1'b0, 16'h0001, 8'h00, 1'b0, 8'h00, 3, 8'h61, 0);

    // Reset while a backend request is outstanding.
    i_req = 1'b1; i_addr = 16'h0040;
    tick;
    chk("midreset.req", {mem_req0, mem_addr0}, {1'b1, 16'h0040});
    rst_n = 1'b0;
    tick;
    chk("midreset.dut0", {i_ack0, i_rdata0, d_ack0, d_rdata0, mem_req0, mem_we0, mem_addr0, mem_wdata0}, 44'h0);
    chk("midreset.dut1", {i_ack1, i_rdata1, d_ack1, d_rdata1, mem_req1, mem_we1, mem_addr1, mem_wdata1}, 44'h0);
    m_irdata = 8'h0; m_drdata = 8'h0; m_wdata = 8'h0; ties = 0;
    rst_n = 1'b1; i_req = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h55;
    tick;
    mem_ack = 1'b0;
    chk_quiet("stray_ack");
    tick;
    chk_quiet("stray_ack2");

    tie(16'h0100, 8'h20, 1'b0, 8'h5A);
    tie(16'h0200, 8'h21, 1'b1, 8'hC3);

    for (int n = 0; n < 30; n++) begin
      int mode;
      mode = $urandom_range(0, 2);
      if (mode == 2) begin
        tie(16'($urandom), 8'($urandom), 1'($urandom), 8'($urandom));
      end else begin
        single(mode == 1, 16'($urandom), 8'($urandom), 1'($urandom), 8'($urandom),
               $urandom_range(0, 3), 8'($urandom), $urandom_range(0, 2));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bf_mem_arbiter.md
Name: bf_mem_arbiter

Overview:
Two-port arbiter that shares one external memory between the bfcpu instruction-fetch port (read-only) and data port (read/write). Instruction space and data space live in one physical memory. Data addresses are relocated by a fixed base offset. Sits between the CPU's i_*/d_* handshake buses and a single req/ack memory backend, and makes both CPU ports see the same level handshake they would get from dedicated memories.

Parameters:
i_addr_width, 16, width of instruction port address
d_addr_width, 8, width of data port address
mem_addr_width, 16, width of backend address; must be >= max(i_addr_width, d_addr_width)
d_base, 16'h8000, backend address of data cell 0 (mem_addr_width bits)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
i_req  in  1  instruction read request, held until i_ack seen
i_addr  in  i_addr_width  instruction address, stable while i_req high
i_ack  out  1  instruction read complete; i_rdata valid while high
i_rdata  out  8  instruction byte
d_req  in  1  data request, held until d_ack seen
d_dir  in  1  0 = read, 1 = write (DIRECTION_READ/DIRECTION_WRITE)
d_addr  in  d_addr_width  data address
d_wdata  in  8  write data
d_ack  out  1  data access complete; d_rdata valid while high on reads
d_rdata  out  8  data read byte
mem_req  out  1  backend request, held until mem_ack
mem_we  out  1  backend write enable
mem_addr  out  mem_addr_width  backend address
mem_wdata  out  8  backend write data
mem_ack  in  1  backend completion pulse; mem_rdata valid in that cycle
mem_rdata  in  8  backend read data

Behaviour:
- Clock and reset: rst_n is synchronous, active-low; clk is the clock. All logic is posedge clk and all outputs are registered.
- Reset values: all outputs 0; state IDLE; last_grant = DATA, so the instruction port wins the first tie.
- Reset mid-transaction: the access is abandoned and mem_req drops the cycle after reset. The backend must tolerate a withdrawn request.
- State machine: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
- IDLE, neither req high: stay in IDLE.
- IDLE, only i_req high: go to BUSY_I.
- IDLE, only d_req high: go to BUSY_D.
- IDLE, both high: round-robin; grant the port not equal to last_grant, then update last_grant.
- On entry to BUSY_I: mem_req=1, mem_we=0, mem_addr = zero-extended i_addr.
- On entry to BUSY_D: mem_req=1, mem_we=d_dir, mem_addr = (d_base + zero-extended d_addr) mod 2^mem_addr_width, mem_wdata=d_wdata.
- Address and data are latched once at grant. Later changes on the port are ignored until the access completes.
- BUSY_x: hold mem_req and all mem_* stable until mem_ack is sampled high.
- On mem_ack: next cycle mem_req=0, the port's ack=1, x_rdata=mem_rdata (data reads only; d_rdata unchanged on writes), go to DONE_x.
- mem_ack sampled while in IDLE or DONE_x is ignored.
- DONE_x: hold the ack and rdata while the port's req is high. When req is sampled low, drop the ack next cycle and return to IDLE.
- A req already low on DONE entry still yields exactly one ack cycle.
- Latency: req sampled in IDLE at cycle N gives mem_req=1 at N+1. mem_ack at cycle M gives port ack=1 at M+1. A new grant is possible no earlier than 1 cycle after the ack drops.
- The losing requester is not dropped. It is granted from the IDLE cycle after the current owner releases.
- Starvation bound: one full transaction.
- Only one backend transaction is ever outstanding. i_ack and d_ack are never high simultaneously.

Test Plan:
- Reset, then i_req with i_addr=16'h0012 and backend returning mem_rdata=8'h2B after 2 cycles -> mem_addr=16'h0012, mem_we=0; i_ack=1 with i_rdata=8'h2B; ack held until i_req drops, then cleared the next cycle.
- d_req write, d_addr=8'h05, d_wdata=8'hA7 -> mem_addr=16'h8005, mem_we=1, mem_wdata=8'hA7; d_ack=1; d_rdata unchanged.
- d_req read at d_addr=8'hFF with d_base=16'hFFF0 -> mem_addr wraps to 16'h00EF.
- i_req and d_req raised in the same cycle right after reset -> instruction granted first. The data access then follows with no request lost. Repeat the tie -> data granted first (alternation).
- Change i_addr from 16'h0001 to 16'h0002 while in BUSY_I -> mem_addr stays 16'h0001 until mem_ack.
- rst_n low while mem_req=1 -> all outputs 0 the next cycle. A stray mem_ack afterwards is ignored and no port ack is produced.
